// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one 32-bit word per line.
// It sits between instruction fetch and the memory controller. A hit returns
// the instruction one cycle after the request is accepted. A miss reads the
// word from memory, fills the line and forwards the word. A ROB rollback
// during a miss suppresses delivery, but the fill still completes.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rdy                 global ready; when low, all state and outputs hold
//   valid_from_if       fetch request, held high until a response is sampled
//   pc_from_if[31:0]    request PC (bits [1:0] ignored)
//   valid_to_if         one-cycle response strobe
//   inst_to_if[31:0]    instruction, valid while valid_to_if is high
//   mem_valid           memory read request, held until mem_done
//   mem_addr[31:0]      word-aligned read address
//   mem_done            one-cycle memory completion
//   mem_data[31:0]      read word, valid together with mem_done
//   rollback_from_rob   pipeline flush
module icache #(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        valid_from_if,
    input  logic [31:0] pc_from_if,
    output logic        valid_to_if,
    output logic [31:0] inst_to_if,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    input  logic        rollback_from_rob
);

    localparam int unsigned TAG_WIDTH = 30 - INDEX_WIDTH;
    localparam int unsigned LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MISS = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [LINES-1:0]        line_valid_q, line_valid_d;
    logic [TAG_WIDTH-1:0]    tag_q  [LINES];
    logic [31:0]             data_q [LINES];
    logic                    vout_q, vout_d;
    logic [31:0]             inst_q, inst_d;
    logic                    mreq_q, mreq_d;
    logic [31:0]             maddr_q, maddr_d;
    logic                    abort_q, abort_d;
    logic                    fill_we_c;

    logic [INDEX_WIDTH-1:0]  req_idx_c;
    logic [TAG_WIDTH-1:0]    req_tag_c;
    logic [INDEX_WIDTH-1:0]  fill_idx_c;
    logic [TAG_WIDTH-1:0]    fill_tag_c;
    logic                    hit_c;
    logic                    unused_pc_bits;

    assign req_idx_c = pc_from_if[INDEX_WIDTH+1:2];
    assign req_tag_c = pc_from_if[31:INDEX_WIDTH+2];
    // The outstanding miss address doubles as the latched PC for the fill.
    assign fill_idx_c = maddr_q[INDEX_WIDTH+1:2];
    assign fill_tag_c = maddr_q[31:INDEX_WIDTH+2];
    assign hit_c      = line_valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
    assign unused_pc_bits = ^pc_from_if[1:0];

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        vout_d       = vout_q;
        inst_d       = inst_q;
        mreq_d       = mreq_q;
        maddr_d      = maddr_q;
        abort_d      = abort_q;
        fill_we_c    = 1'b0;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (valid_from_if && !rollback_from_rob) begin
                        if (hit_c) begin
                            inst_d  = data_q[req_idx_c];
                            vout_d  = 1'b1;
                            state_d = S_RESP;
                        end else begin
                            mreq_d  = 1'b1;
                            maddr_d = {pc_from_if[31:2], 2'b00};
                            abort_d = 1'b0;
                            state_d = S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (mem_done) begin
                        // The fill is always correct for its address, so it
                        // lands even when delivery has been aborted.
                        fill_we_c                = 1'b1;
                        line_valid_d[fill_idx_c] = 1'b1;
                        mreq_d                   = 1'b0;
                        if (!abort_q && !rollback_from_rob) begin
                            inst_d  = mem_data;
                            vout_d  = 1'b1;
                            state_d = S_RESP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (rollback_from_rob) begin
                        abort_d = 1'b1;
                    end
                end
                S_RESP: begin
                    // Fetch drops its request on the edge that consumes the
                    // response, so any request still visible here is stale.
                    vout_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state and line valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_valid_q <= '0;
            vout_q       <= 1'b0;
            inst_q       <= 32'd0;
            mreq_q       <= 1'b0;
            maddr_q      <= 32'd0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            vout_q       <= vout_d;
            inst_q       <= inst_d;
            mreq_q       <= mreq_d;
            maddr_q      <= maddr_d;
            abort_q      <= abort_d;
        end
    end

    // Tag and data arrays; their contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            tag_q[fill_idx_c]  <= fill_tag_c;
            data_q[fill_idx_c] <= mem_data;
        end
    end

    assign valid_to_if = vout_q;
    assign inst_to_if  = inst_q;
    assign mem_valid   = mreq_q;
    assign mem_addr    = maddr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache. The driver predicts each response
// from a line-level cache model and pushes it to a queue; a monitor pops it
// when the DUT strobes valid_to_if. A memory responder answers read requests
// and checks their addresses against a second queue.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        valid_from_if;
    logic [31:0] pc_from_if;
    logic        valid_to_if;
    logic [31:0] inst_to_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        rollback_from_rob;
    logic        rb_drv;
    logic        rb_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] sbq[$];
    logic [31:0] addrq[$];

    // Reference model: one entry per line.
    bit          mv [64];
    logic [23:0] mt [64];
    logic [31:0] md [64];

    int resp_lat   = 3;
    bit rb_on_done = 1'b0;
    bit prev_v     = 1'b0;

    assign rollback_from_rob = rb_drv | rb_done;

    icache dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .valid_from_if    (valid_from_if),
        .pc_from_if       (pc_from_if),
        .valid_to_if      (valid_to_if),
        .inst_to_if       (inst_to_if),
        .mem_valid        (mem_valid),
        .mem_addr         (mem_addr),
        .mem_done         (mem_done),
        .mem_data         (mem_data),
        .rollback_from_rob(rollback_from_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0)   return 32'h0000_0013;
        if (a == 32'h100) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        int idx;
        idx = int'(pc[7:2]);
        return mv[idx] && (mt[idx] == pc[31:8]);
    endfunction

    task automatic model_fill(input logic [31:0] a);
        int idx;
        idx = int'(a[7:2]);
        mv[idx] = 1'b1;
        mt[idx] = a[31:8];
        md[idx] = word_at(a);
    endtask

    // Monitor: every strobe must match the oldest expected response.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (valid_to_if) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_response: got inst %h expected no strobe", inst_to_if);
                end else begin
                    logic [31:0] e;
                    e = sbq.pop_front();
                    if (inst_to_if !== e) begin
                        errors++;
                        $display("FAIL inst_to_if: got %h expected %h", inst_to_if, e);
                    end
                end
                if (prev_v) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_width: got 2+ cycles expected 1");
                end
            end
            prev_v = valid_to_if;
        end
    end

    // Memory responder: checks the request address, answers after resp_lat.
    initial begin
        mem_done = 1'b0;
        mem_data = 32'd0;
        rb_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mem_valid) begin
                bit killed;
                int lat;
                killed = 1'b0;
                if (addrq.size() == 0) begin
                    check("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] ea;
                    ea = addrq.pop_front();
                    check("mem_addr", mem_addr, ea);
                end
                lat = (resp_lat != 0) ? resp_lat : int'($urandom_range(2, 4));
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        killed = 1'b1;
                        break;
                    end
                end
                if (!killed) begin
                    mem_done = 1'b1;
                    mem_data = word_at(mem_addr);
                    rb_done  = rb_on_done;
                    @(negedge clk);
                    mem_done = 1'b0;
                    rb_done  = 1'b0;
                    mem_data = $urandom;
                end
            end
        end
    end

    // One fetch request; optionally holds the request through the RESP edge,
    // or stalls rdy for five cycles right after a miss is accepted.
    task automatic do_req(input logic [31:0] pc, input bit hold_extra, input bit stall);
        logic [31:0] a;
        bit hit, got, saw_mem;
        a   = {pc[31:2], 2'b00};
        hit = model_hit(pc);
        if (hit) begin
            sbq.push_back(md[int'(pc[7:2])]);
        end else begin
            addrq.push_back(a);
            model_fill(a);
            sbq.push_back(word_at(a));
        end
        @(negedge clk);
        valid_from_if = 1'b1;
        pc_from_if    = pc;
        got = 1'b0;
        saw_mem = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            if (mem_valid) saw_mem = 1'b1;
            if (stall && c == 0) begin
                rdy = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_mem_valid", 32'(mem_valid), 32'd1);
                    check("stall_mem_addr", mem_addr, a);
                    check("stall_valid_to_if", 32'(valid_to_if), 32'd0);
                end
                rdy = 1'b1;
            end
            if (valid_to_if) got = 1'b1;
        end
        check("response_seen", 32'(got), 32'd1);
        check("mem_req_on_miss_only", 32'(saw_mem), 32'(!hit));
        if (hold_extra) @(negedge clk);
        valid_from_if = 1'b0;
    endtask

    task automatic wait_mem_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (!mem_valid) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Miss with a rollback pulsed before mem_done: no delivery, line filled.
    task automatic do_abort(input logic [31:0] pc);
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        if (model_hit(pc)) begin
            do_req(pc, 1'b0, 1'b0);
        end else begin
            addrq.push_back(a);
            model_fill(a);
            @(negedge clk);
            valid_from_if = 1'b1;
            pc_from_if    = pc;
            @(negedge clk);
            valid_from_if = 1'b0;
            rb_drv        = 1'b1;
            @(negedge clk);
            rb_drv = 1'b0;
            check("abort_keeps_mem_valid", 32'(mem_valid), 32'd1);
            wait_mem_idle("abort_mem_done");
            repeat (2) @(negedge clk);
        end
    endtask

    // Miss whose rollback coincides with mem_done.
    task automatic do_rb_on_done(input logic [31:0] pc);
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        addrq.push_back(a);
        model_fill(a);
        rb_on_done = 1'b1;
        @(negedge clk);
        valid_from_if = 1'b1;
        pc_from_if    = pc;
        @(negedge clk);
        valid_from_if = 1'b0;
        wait_mem_idle("rb_done_mem_done");
        rb_on_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        valid_from_if = 1'b0;
        pc_from_if = 32'd0;
        rb_drv = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            mt[i] = 24'd0;
            md[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        check("rst_valid_to_if", 32'(valid_to_if), 32'd0);
        check("rst_inst_to_if", inst_to_if, 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // Cold miss, hits (low PC bits ignored), conflict eviction.
        resp_lat = 3;
        do_req(32'h0, 1'b0, 1'b0);
        do_req(32'h0, 1'b0, 1'b0);
        do_req(32'h2, 1'b0, 1'b0);
        do_req(32'h100, 1'b0, 1'b0);
        do_req(32'h0, 1'b0, 1'b0);

        // Rollbacks during a miss and on the completion cycle.
        resp_lat = 0;
        do_abort(32'h200);
        do_req(32'h200, 1'b0, 1'b0);
        do_rb_on_done(32'h300);
        do_req(32'h300, 1'b1, 1'b0);
        do_req(32'h300, 1'b1, 1'b0);

        // rdy held low mid-miss.
        resp_lat = 12;
        do_req(32'h400, 1'b0, 1'b1);
        resp_lat = 0;

        // Randomized traffic over a small set of conflicting lines.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] pc;
            int r;
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (r < 2 && !model_hit(pc)) do_abort(pc);
            else if (r < 4)              do_req(pc, 1'b1, 1'b0);
            else                         do_req(pc, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a miss.
        resp_lat = 20;
        addrq.push_back(32'h3F00);
        @(negedge clk);
        valid_from_if = 1'b1;
        pc_from_if    = 32'h3F00;
        @(negedge clk);
        valid_from_if = 1'b0;
        check("pre_reset_mem_valid", 32'(mem_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_mem_valid", 32'(mem_valid), 32'd0);
        check("async_rst_valid_to_if", 32'(valid_to_if), 32'd0);
        sbq.delete();
        addrq.delete();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        resp_lat = 0;
        do_req(32'h0, 1'b0, 1'b0);
        do_req(32'h0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("pending_responses", 32'(sbq.size()), 32'd0);
        check("pending_mem_reqs", 32'(addrq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
